// File: rtl/ucsbece154b_defines.sv
// Shared definitions for the in-order commit (retire) buffer.
//   DEF_DEPTH / DEF_TAGW : default entry count and tag width
//   RD_W / DATA_W        : register-address and result-data widths
//   REG_ZERO             : x0; an entry targeting it never writes the RF
//   entry_t              : one buffer entry {valid, done, we, rd, data}
package ucsbece154b_defines;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_TAGW  = 3;
    localparam int RD_W      = 5;
    localparam int DATA_W    = 32;

    localparam logic [RD_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              we;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/ucsbece154b_commit.sv
// In-order retire buffer feeding both write ports of a dual-issue register file.
//   clk, reset            : clock, synchronous active-high reset
//   flush_i               : drop every un-retired entry
//   alloc_*               : up to two in-order allocations per cycle from decode
//   alloc_rdy_o           : at least two free entries (registered count only)
//   alloc_tag1_o/2_o      : tags handed to the two decode slots
//   cmp_*                 : two out-of-order completion lanes, addressed by tag
//   we3/a3/wd3_o1,_o2     : RF write ports; slot 1 = older, slot 2 = younger
//   retire_cnt_o          : entries retired this cycle (0..2)
//   count_o               : occupied entries
module ucsbece154b_commit
    import ucsbece154b_defines::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAGW  = DEF_TAGW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,

    input  logic              alloc_v1_i,
    input  logic              alloc_v2_i,
    input  logic [RD_W-1:0]   alloc_rd1_i,
    input  logic [RD_W-1:0]   alloc_rd2_i,
    input  logic              alloc_we1_i,
    input  logic              alloc_we2_i,
    output logic              alloc_rdy_o,
    output logic [TAGW-1:0]   alloc_tag1_o,
    output logic [TAGW-1:0]   alloc_tag2_o,

    input  logic              cmp_v1_i,
    input  logic [TAGW-1:0]   cmp_tag1_i,
    input  logic [DATA_W-1:0] cmp_wd1_i,
    input  logic              cmp_v2_i,
    input  logic [TAGW-1:0]   cmp_tag2_i,
    input  logic [DATA_W-1:0] cmp_wd2_i,

    output logic              we3_o1,
    output logic [RD_W-1:0]   a3_o1,
    output logic [DATA_W-1:0] wd3_o1,
    output logic              we3_o2,
    output logic [RD_W-1:0]   a3_o2,
    output logic [DATA_W-1:0] wd3_o2,
    output logic [1:0]        retire_cnt_o,
    output logic [TAGW:0]     count_o
);

    localparam int PTR_W = TAGW + 1;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [TAGW-1:0]  hidx1, hidx2;
    entry_t           e1, e2;
    logic             r1, r2, same_rd;
    logic             a1, a2;

    // ------------------------------------------------------------------
    // Occupancy and allocation handshake
    // ------------------------------------------------------------------
    // Wrap bit makes tail-head the exact occupancy, including full.
    assign count_o      = tail_q - head_q;
    assign alloc_rdy_o  = (count_o <= PTR_W'(DEPTH - 2));
    assign alloc_tag1_o = tail_q[TAGW-1:0];
    assign alloc_tag2_o = alloc_v1_i ? (tail_q[TAGW-1:0] + TAGW'(1)) : tail_q[TAGW-1:0];

    assign a1 = alloc_v1_i & alloc_rdy_o & ~flush_i;
    assign a2 = alloc_v2_i & alloc_rdy_o & ~flush_i;

    // ------------------------------------------------------------------
    // Retire selection (from registered entries only)
    // ------------------------------------------------------------------
    assign hidx1 = head_q[TAGW-1:0];
    assign hidx2 = hidx1 + TAGW'(1);
    assign e1    = ent_q[hidx1];
    assign e2    = ent_q[hidx2];

    // Reset suppresses RF writes in the cycle it is asserted.
    assign r1 = ~reset & e1.valid & e1.done;
    assign r2 = r1 & e2.valid & e2.done;

    // Both retiring entries hit the same register: only the younger lands.
    assign same_rd = r2 & e1.we & e2.we & (e1.rd == e2.rd);

    assign we3_o1 = r1 & e1.we & ~same_rd;
    assign a3_o1  = r1 ? e1.rd   : REG_ZERO;
    assign wd3_o1 = r1 ? e1.data : '0;
    assign we3_o2 = r2 & e2.we;
    assign a3_o2  = r2 ? e2.rd   : REG_ZERO;
    assign wd3_o2 = r2 ? e2.data : '0;

    assign retire_cnt_o = {r2, r1 & ~r2};

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // Alloc targets free slots and completion/retire target valid ones,
    // so the three updates never collide on one entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        head_d = head_q + PTR_W'(retire_cnt_o);
        tail_d = tail_q + PTR_W'(a1) + PTR_W'(a2);

        // Lane 2 is applied last so it wins a same-tag collision.
        if (cmp_v1_i && ent_q[cmp_tag1_i].valid) begin
            ent_d[cmp_tag1_i].data = cmp_wd1_i;
            ent_d[cmp_tag1_i].done = 1'b1;
        end
        if (cmp_v2_i && ent_q[cmp_tag2_i].valid) begin
            ent_d[cmp_tag2_i].data = cmp_wd2_i;
            ent_d[cmp_tag2_i].done = 1'b1;
        end

        if (r1) begin
            ent_d[hidx1].valid = 1'b0;
            ent_d[hidx1].done  = 1'b0;
        end
        if (r2) begin
            ent_d[hidx2].valid = 1'b0;
            ent_d[hidx2].done  = 1'b0;
        end

        if (a1) begin
            ent_d[alloc_tag1_o].valid = 1'b1;
            ent_d[alloc_tag1_o].done  = 1'b0;
            ent_d[alloc_tag1_o].we    = alloc_we1_i & (alloc_rd1_i != REG_ZERO);
            ent_d[alloc_tag1_o].rd    = alloc_rd1_i;
            ent_d[alloc_tag1_o].data  = '0;
        end
        if (a2) begin
            ent_d[alloc_tag2_o].valid = 1'b1;
            ent_d[alloc_tag2_o].done  = 1'b0;
            ent_d[alloc_tag2_o].we    = alloc_we2_i & (alloc_rd2_i != REG_ZERO);
            ent_d[alloc_tag2_o].rd    = alloc_rd2_i;
            ent_d[alloc_tag2_o].data  = '0;
        end

        // Flush keeps this cycle's retires (head_d already advanced).
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
            tail_d = head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_ucsbece154b_commit.sv
module tb_ucsbece154b_commit;

    localparam int DEPTH = 8;
    localparam int TAGW  = 3;

    logic        clk = 1'b0;
    logic        reset, flush_i;
    logic        alloc_v1_i, alloc_v2_i, alloc_we1_i, alloc_we2_i;
    logic [4:0]  alloc_rd1_i, alloc_rd2_i;
    logic        alloc_rdy_o;
    logic [2:0]  alloc_tag1_o, alloc_tag2_o;
    logic        cmp_v1_i, cmp_v2_i;
    logic [2:0]  cmp_tag1_i, cmp_tag2_i;
    logic [31:0] cmp_wd1_i, cmp_wd2_i;
    logic        we3_o1, we3_o2;
    logic [4:0]  a3_o1, a3_o2;
    logic [31:0] wd3_o1, wd3_o2;
    logic [1:0]  retire_cnt_o;
    logic [3:0]  count_o;

    ucsbece154b_commit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .alloc_v1_i(alloc_v1_i), .alloc_v2_i(alloc_v2_i),
        .alloc_rd1_i(alloc_rd1_i), .alloc_rd2_i(alloc_rd2_i),
        .alloc_we1_i(alloc_we1_i), .alloc_we2_i(alloc_we2_i),
        .alloc_rdy_o(alloc_rdy_o), .alloc_tag1_o(alloc_tag1_o), .alloc_tag2_o(alloc_tag2_o),
        .cmp_v1_i(cmp_v1_i), .cmp_tag1_i(cmp_tag1_i), .cmp_wd1_i(cmp_wd1_i),
        .cmp_v2_i(cmp_v2_i), .cmp_tag2_i(cmp_tag2_i), .cmp_wd2_i(cmp_wd2_i),
        .we3_o1(we3_o1), .a3_o1(a3_o1), .wd3_o1(wd3_o1),
        .we3_o2(we3_o2), .a3_o2(a3_o2), .wd3_o2(wd3_o2),
        .retire_cnt_o(retire_cnt_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: program-order queue ----------------
    typedef struct {
        int          tag;
        bit          done;
        bit          we;
        int          rd;
        int unsigned data;
    } ment_t;

    ment_t q[$];
    int    next_tag;
    int    n_chk, n_pass;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic int exp_rc();
        bit r1, r2;
        r1 = !reset && q.size() >= 1 && q[0].done;
        r2 = r1 && q.size() >= 2 && q[1].done;
        return r2 ? 2 : (r1 ? 1 : 0);
    endfunction

    // Compare every output with what the queue says it must be.
    task automatic check();
        int  rc;
        bit  w1, w2;
        int  rd1, rd2;
        int unsigned d1, d2;
        rc  = exp_rc();
        rd1 = (rc >= 1) ? q[0].rd   : 0;
        d1  = (rc >= 1) ? q[0].data : 0;
        rd2 = (rc == 2) ? q[1].rd   : 0;
        d2  = (rc == 2) ? q[1].data : 0;
        w2  = (rc == 2) && q[1].we;
        w1  = (rc >= 1) && q[0].we && !(w2 && rd1 == rd2);
        chk("count",      32'(count_o),      32'(q.size()));
        chk("alloc_rdy",  32'(alloc_rdy_o),  32'(DEPTH - q.size() >= 2));
        chk("alloc_tag1", 32'(alloc_tag1_o), 32'(next_tag));
        chk("alloc_tag2", 32'(alloc_tag2_o), 32'(alloc_v1_i ? (next_tag + 1) % DEPTH : next_tag));
        chk("retire_cnt", 32'(retire_cnt_o), 32'(rc));
        chk("we3_o1",     32'(we3_o1),       32'(w1));
        chk("a3_o1",      32'(a3_o1),        32'(rd1));
        chk("wd3_o1",     wd3_o1,            d1);
        chk("we3_o2",     32'(we3_o2),       32'(w2));
        chk("a3_o2",      32'(a3_o2),        32'(rd2));
        chk("wd3_o2",     wd3_o2,            d2);
    endtask

    task automatic complete(int tag, int unsigned data);
        foreach (q[i]) if (q[i].tag == tag) begin
            q[i].done = 1'b1;
            q[i].data = data;
        end
    endtask

    // Advance the model across one rising edge using the held inputs.
    task automatic mstep();
        int  rc;
        bit  rdy;
        ment_t e;
        if (reset) begin
            q.delete();
            next_tag = 0;
            return;
        end
        rc  = exp_rc();
        rdy = (DEPTH - q.size()) >= 2;
        if (cmp_v1_i) complete(int'(cmp_tag1_i), cmp_wd1_i);
        if (cmp_v2_i) complete(int'(cmp_tag2_i), cmp_wd2_i);
        repeat (rc) void'(q.pop_front());
        if (flush_i) begin
            next_tag = (next_tag - q.size() + DEPTH) % DEPTH;
            q.delete();
        end else if (rdy) begin
            if (alloc_v1_i) begin
                e = '{tag: next_tag, done: 0, we: alloc_we1_i && alloc_rd1_i != 0, rd: int'(alloc_rd1_i), data: 0};
                q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
            if (alloc_v2_i) begin
                e = '{tag: next_tag, done: 0, we: alloc_we2_i && alloc_rd2_i != 0, rd: int'(alloc_rd2_i), data: 0};
                q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        reset = 0; flush_i = 0;
        alloc_v1_i = 0; alloc_v2_i = 0; alloc_we1_i = 0; alloc_we2_i = 0;
        alloc_rd1_i = 0; alloc_rd2_i = 0;
        cmp_v1_i = 0; cmp_v2_i = 0; cmp_tag1_i = 0; cmp_tag2_i = 0;
        cmp_wd1_i = 0; cmp_wd2_i = 0;
    endtask

    task automatic settle(); #1; endtask

    task automatic cyc();
        check();
        mstep();
        @(negedge clk);
        idle();
    endtask

    task automatic go(); settle(); cyc(); endtask

    task automatic alloc2(int rd1, bit we1, int rd2, bit we2);
        alloc_v1_i = 1; alloc_rd1_i = 5'(rd1); alloc_we1_i = we1;
        alloc_v2_i = 1; alloc_rd2_i = 5'(rd2); alloc_we2_i = we2;
    endtask

    task automatic cmp2(int t1, int unsigned d1, int t2, int unsigned d2);
        cmp_v1_i = 1; cmp_tag1_i = 3'(t1); cmp_wd1_i = d1;
        cmp_v2_i = 1; cmp_tag2_i = 3'(t2); cmp_wd2_i = d2;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; next_tag = 0;
        idle();
        reset = 1;
        @(negedge clk); @(negedge clk);
        reset = 1; go();                       // model cleared too
        settle();
        chk("rst_count", 32'(count_o), 0);
        chk("rst_rdy", 32'(alloc_rdy_o), 1);
        chk("rst_rc", 32'(retire_cnt_o), 0);
        chk("rst_we", 32'({we3_o1, we3_o2}), 0);
        cyc();

        // 1: alloc x1,x2 then complete both together
        alloc2(1, 1, 2, 1); go();
        cmp2(0, 32'h11, 1, 32'h22); go();
        settle();
        chk("t1_rc", 32'(retire_cnt_o), 2);
        chk("t1_we", 32'({we3_o1, we3_o2}), 32'b11);
        chk("t1_a3", 32'({a3_o1, a3_o2}), 32'({5'd1, 5'd2}));
        chk("t1_wd1", wd3_o1, 32'h11);
        cyc();

        // 2: out-of-order completion (tags 2,3)
        alloc2(3, 1, 4, 1); go();
        cmp_v1_i = 1; cmp_tag1_i = 3; cmp_wd1_i = 32'h44; go();
        cmp_v1_i = 1; cmp_tag1_i = 2; cmp_wd1_i = 32'h33; settle();
        chk("t2_hold", 32'(retire_cnt_o), 0);
        cyc();
        settle();
        chk("t2_rc", 32'(retire_cnt_o), 2);
        chk("t2_a3", 32'({a3_o1, a3_o2}), 32'({5'd3, 5'd4}));
        cyc();

        // 3: same destination in both slots (tags 4,5)
        alloc2(5, 1, 5, 1); go();
        cmp2(4, 32'hA, 5, 32'hB); go();
        settle();
        chk("t3_we", 32'({we3_o1, we3_o2}), 32'b01);
        chk("t3_wd2", wd3_o2, 32'hB);
        cyc();

        // 5: x0 destination never writes (tag 6)
        alloc_v1_i = 1; alloc_rd1_i = 0; alloc_we1_i = 1; go();
        cmp_v1_i = 1; cmp_tag1_i = 6; cmp_wd1_i = 32'hFFFF; go();
        settle();
        chk("t5_rc", 32'(retire_cnt_o), 1);
        chk("t5_we", 32'(we3_o1), 0);
        cyc();
        settle();
        chk("t5_cnt", 32'(count_o), 0);
        cyc();

        // 4: fill to full, extra alloc ignored, drain two, then wrap
        repeat (4) begin alloc2(7, 1, 8, 1); go(); end
        settle();
        chk("t4_full", 32'(count_o), 8);
        chk("t4_rdy", 32'(alloc_rdy_o), 0);
        cyc();
        alloc2(9, 1, 9, 1); go();
        settle();
        chk("t4_ign", 32'(count_o), 8);
        cyc();
        cmp2(q[0].tag, 32'h70, q[1].tag, 32'h80); go();
        go();
        settle();
        chk("t4_rdy2", 32'(alloc_rdy_o), 1);
        cyc();
        for (int i = 0; i < 20; i++) begin
            alloc2(10 + i, 1, 11 + i, 1);
            cmp2(q[0].tag, $urandom, q[1].tag, $urandom);
            go();
        end
        while (q.size() != 0) begin
            if (q.size() >= 2) cmp2(q[0].tag, $urandom, q[1].tag, $urandom);
            else begin cmp_v1_i = 1; cmp_tag1_i = 3'(q[0].tag); cmp_wd1_i = $urandom; end
            go(); go();
        end

        // 6: flush with 4 pending and head done
        alloc2(12, 1, 13, 1); go();
        alloc2(14, 1, 15, 1); go();
        cmp_v1_i = 1; cmp_tag1_i = 3'(q[0].tag); cmp_wd1_i = 32'h1234; go();
        flush_i = 1; alloc2(16, 1, 17, 1); settle();
        chk("t6_rc", 32'(retire_cnt_o), 1);
        chk("t6_wd", wd3_o1, 32'h1234);
        cyc();
        settle();
        chk("t6_cnt", 32'(count_o), 0);
        cyc();

        // reset mid-stream with completed entries pending
        alloc2(18, 1, 19, 1); go();
        cmp2(q[0].tag, 32'h5, q[1].tag, 32'h6); go();
        reset = 1; settle();
        chk("rst_nowr", 32'({we3_o1, we3_o2, retire_cnt_o}), 0);
        cyc();
        settle();
        chk("rst_cnt0", 32'(count_o), 0);
        cyc();

        // randomized traffic against the queue model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) < 70) begin
                alloc_v1_i = 1; alloc_rd1_i = 5'($urandom); alloc_we1_i = 1'($urandom);
                if ($urandom_range(1) == 1) begin
                    alloc_v2_i = 1; alloc_rd2_i = 5'($urandom); alloc_we2_i = 1'($urandom);
                end
            end
            if ($urandom_range(99) < 60) begin
                cmp_v1_i = 1; cmp_wd1_i = $urandom;
                cmp_tag1_i = (q.size() > 0 && $urandom_range(9) != 0)
                           ? 3'(q[$urandom_range(q.size() - 1)].tag) : 3'($urandom);
            end
            if ($urandom_range(99) < 50) begin
                cmp_v2_i = 1; cmp_wd2_i = $urandom;
                cmp_tag2_i = ($urandom_range(7) == 0) ? cmp_tag1_i
                           : (q.size() > 0) ? 3'(q[$urandom_range(q.size() - 1)].tag) : 3'($urandom);
            end
            flush_i = ($urandom_range(99) < 2);
            reset   = ($urandom_range(199) < 1);
            go();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
